// File: rtl/ack_parser_if.sv
// Word stream from the UDT decode stage into ack_parser.
// The master drives the packet words; the slave (ack_parser) returns in_tready.
interface ack_parser_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0]   in_tdata;
  logic [DATA_W/8-1:0] in_tkeep;
  logic                in_tvalid;
  logic                in_tready;
  logic                in_tlast;

  modport master (output in_tdata, in_tkeep, in_tvalid, in_tlast, input in_tready);
  modport slave  (input in_tdata, in_tkeep, in_tvalid, in_tlast, output in_tready);
endinterface

// File: rtl/ack_parser.sv
// Parses UDT full/light ACK control packets into registered fields and ACK2 requests.
// Optional macro ACK_RATE_FIELDS_EN builds the receive-rate / link-capacity registers.
module ack_parser #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          CNT_W              = 16,
  parameter logic [14:0] ACK_TYPE           = 15'h0002
) (
  input  logic             core_clk,
  input  logic             core_rst_n,
  ack_parser_if.slave      in_if,
  input  logic             ack_en,
  output logic             ack_valid,
  output logic             ack_light,
  output logic [30:0]      ack_seqno,
  output logic [31:0]      ack_rtt,
  output logic [31:0]      ack_rttvar,
  output logic [31:0]      ack_avail_buf,
  output logic [31:0]      ack_rcv_rate,
  output logic [31:0]      ack_link_cap,
  output logic             ack2_valid,
  output logic [31:0]      ack2_ackno,
  input  logic             ack2_ready,
  output logic [CNT_W-1:0] malformed_cnt,
  output logic [CNT_W-1:0] stale_cnt,
  output logic [CNT_W-1:0] ack2_drop_cnt
);
  typedef enum logic [2:0] {IDLE, SKIP, HDR, BODY, COMMIT} state_e;

  typedef struct packed {
    logic [31:0] rtt;
    logic [31:0] rttvar;
    logic [31:0] avail_buf;
  } fields_t;

  typedef struct packed {
    logic [31:0] sub_seq;
    logic [31:0] seqno;
    fields_t     f;
  } body_t;

  // Beat index saturates here; anything at or past it only matters as ">= 9".
  localparam logic [3:0] BEAT_MAX = 4'd10;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e                  state_q, state_d;
  logic [3:0]              beat_q, beat_d;
  logic                    type_ok_q, type_ok_d;
  body_t                   body_q, body_d;
  fields_t                 fields_q, fields_d;
  logic                    have_seq_q, have_seq_d;
  logic                    ack_valid_q, ack_valid_d;
  logic                    ack_light_q, ack_light_d;
  logic [30:0]             ack_seqno_q, ack_seqno_d;
  logic                    ack2_valid_q, ack2_valid_d;
  logic [31:0]             ack2_ackno_q, ack2_ackno_d;
  logic [CNT_W-1:0]        malformed_q, malformed_d;
  logic [CNT_W-1:0]        stale_q, stale_d;
  logic [CNT_W-1:0]        drop_q, drop_d;

  logic [C_S_AXI_DATA_WIDTH-1:0] data;
  logic        beat, in_ack_pkt, commit, is_light, is_full, fresh, take_full;
  logic [30:0] seq_dist;
  logic        unused_tkeep;

  assign data            = in_if.in_tdata;
  assign in_if.in_tready = (state_q != COMMIT);
  assign beat            = in_if.in_tvalid & in_if.in_tready;
  assign in_ack_pkt      = (state_q == HDR) || (state_q == BODY);
  assign unused_tkeep    = ^in_if.in_tkeep;

  // NOTE: every signal gets its default before any branch, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    type_ok_d    = type_ok_q;
    body_d       = body_q;
    fields_d     = fields_q;
    have_seq_d   = have_seq_q;
    ack_valid_d  = 1'b0;
    ack_light_d  = ack_light_q;
    ack_seqno_d  = ack_seqno_q;
    ack2_valid_d = ack2_valid_q;
    ack2_ackno_d = ack2_ackno_q;
    malformed_d  = malformed_q;
    stale_d      = stale_q;
    drop_d       = drop_q;
    commit       = 1'b0;
    take_full    = 1'b0;

    if (beat) begin
      beat_d = in_if.in_tlast ? 4'd0 : ((beat_q == BEAT_MAX) ? beat_q : beat_q + 4'd1);
      if (in_ack_pkt) begin
        case (beat_q)
          4'd1:    body_d.sub_seq     = data;
          4'd4:    body_d.seqno       = data;
          4'd5:    body_d.f.rtt       = data;
          4'd6:    body_d.f.rttvar    = data;
          4'd7:    body_d.f.avail_buf = data;
          default: ;
        endcase
      end
    end

    unique case (state_q)
      IDLE: if (beat) begin
        type_ok_d = data[31] && (data[30:16] == ACK_TYPE);
        if (!ack_en)             state_d = in_if.in_tlast ? IDLE : SKIP;
        else if (in_if.in_tlast) begin state_d = COMMIT; commit = 1'b1; end
        else                     state_d = HDR;
      end
      SKIP:   if (beat && in_if.in_tlast) state_d = IDLE;
      HDR: if (beat) begin
        if (in_if.in_tlast)     begin state_d = COMMIT; commit = 1'b1; end
        else if (beat_q == 4'd3) state_d = BODY;
      end
      BODY:   if (beat && in_if.in_tlast) begin state_d = COMMIT; commit = 1'b1; end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A beat-0 commit leaves beat_q at 0, so a stale type_ok_q cannot classify it.
    is_light = commit && type_ok_q && (beat_q == 4'd4) && !body_d.seqno[31];
    is_full  = commit && type_ok_q && (beat_q >= 4'd9) && !body_d.seqno[31];
    seq_dist = body_d.seqno[30:0] - ack_seqno_q;
    fresh    = !have_seq_q || ((seq_dist != 31'd0) && !seq_dist[30]);

    if (commit && !is_light && !is_full) begin
      malformed_d = sat_inc(malformed_q);
    end else if ((is_light || is_full) && !fresh) begin
      stale_d = sat_inc(stale_q);
    end else if (is_light || is_full) begin
      ack_valid_d = 1'b1;
      ack_light_d = is_light;
      ack_seqno_d = body_d.seqno[30:0];
      have_seq_d  = 1'b1;
      take_full   = is_full;
      if (is_full) fields_d = body_d.f;
    end

    // ACK2 echoes every well-formed full ACK, even a stale one.
    if (is_full) begin
      ack2_valid_d = 1'b1;
      ack2_ackno_d = body_d.sub_seq;
      if (ack2_valid_q && !ack2_ready) drop_d = sat_inc(drop_q);
    end else if (ack2_ready) begin
      ack2_valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      type_ok_q    <= 1'b0;
      body_q       <= '0;
      fields_q     <= '0;
      have_seq_q   <= 1'b0;
      ack_valid_q  <= 1'b0;
      ack_light_q  <= 1'b0;
      ack_seqno_q  <= '0;
      ack2_valid_q <= 1'b0;
      ack2_ackno_q <= '0;
      malformed_q  <= '0;
      stale_q      <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      type_ok_q    <= type_ok_d;
      body_q       <= body_d;
      fields_q     <= fields_d;
      have_seq_q   <= have_seq_d;
      ack_valid_q  <= ack_valid_d;
      ack_light_q  <= ack_light_d;
      ack_seqno_q  <= ack_seqno_d;
      ack2_valid_q <= ack2_valid_d;
      ack2_ackno_q <= ack2_ackno_d;
      malformed_q  <= malformed_d;
      stale_q      <= stale_d;
      drop_q       <= drop_d;
    end
  end

`ifdef ACK_RATE_FIELDS_EN
  logic [31:0] rate_sh_q, rate_sh_d, cap_sh_q, cap_sh_d;
  logic [31:0] rcv_rate_q, rcv_rate_d, link_cap_q, link_cap_d;

  always_comb begin
    rate_sh_d  = rate_sh_q;
    cap_sh_d   = cap_sh_q;
    rcv_rate_d = rcv_rate_q;
    link_cap_d = link_cap_q;
    if (beat && in_ack_pkt && (beat_q == 4'd8)) rate_sh_d = data;
    if (beat && in_ack_pkt && (beat_q == 4'd9)) cap_sh_d  = data;
    if (take_full) begin
      rcv_rate_d = rate_sh_d;
      link_cap_d = cap_sh_d;
    end
  end

  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      rate_sh_q  <= '0;
      cap_sh_q   <= '0;
      rcv_rate_q <= '0;
      link_cap_q <= '0;
    end else begin
      rate_sh_q  <= rate_sh_d;
      cap_sh_q   <= cap_sh_d;
      rcv_rate_q <= rcv_rate_d;
      link_cap_q <= link_cap_d;
    end
  end

  assign ack_rcv_rate = rcv_rate_q;
  assign ack_link_cap = link_cap_q;
`else
  logic unused_take_full;
  assign unused_take_full = take_full;
  assign ack_rcv_rate     = 32'd0;
  assign ack_link_cap     = 32'd0;
`endif

  assign ack_valid     = ack_valid_q;
  assign ack_light     = ack_light_q;
  assign ack_seqno     = ack_seqno_q;
  assign ack_rtt       = fields_q.rtt;
  assign ack_rttvar    = fields_q.rttvar;
  assign ack_avail_buf = fields_q.avail_buf;
  assign ack2_valid    = ack2_valid_q;
  assign ack2_ackno    = ack2_ackno_q;
  assign malformed_cnt = malformed_q;
  assign stale_cnt     = stale_q;
  assign ack2_drop_cnt = drop_q;
endmodule

// File: tb/tb_ack_parser.sv
// Self-checking bench for ack_parser: packet-level reference model plus directed and random packets.
`timescale 1ns/1ps
module tb_ack_parser;
  // Narrow counters so saturation is reachable within the random phase.
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [31:0] wq_t[$];

  logic             core_clk = 1'b0;
  logic             core_rst_n = 1'b0;
  logic             ack_en = 1'b0;
  logic             ack2_ready = 1'b0;
  logic             ack_valid, ack_light, ack2_valid;
  logic [30:0]      ack_seqno;
  logic [31:0]      ack_rtt, ack_rttvar, ack_avail_buf, ack_rcv_rate, ack_link_cap, ack2_ackno;
  logic [CNT_W-1:0] malformed_cnt, stale_cnt, ack2_drop_cnt;

  ack_parser_if bus();

  ack_parser #(.CNT_W(CNT_W)) dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n), .in_if(bus), .ack_en(ack_en),
    .ack_valid(ack_valid), .ack_light(ack_light), .ack_seqno(ack_seqno),
    .ack_rtt(ack_rtt), .ack_rttvar(ack_rttvar), .ack_avail_buf(ack_avail_buf),
    .ack_rcv_rate(ack_rcv_rate), .ack_link_cap(ack_link_cap),
    .ack2_valid(ack2_valid), .ack2_ackno(ack2_ackno), .ack2_ready(ack2_ready),
    .malformed_cnt(malformed_cnt), .stale_cnt(stale_cnt), .ack2_drop_cnt(ack2_drop_cnt)
  );

  always #5 core_clk = ~core_clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;
  int rdy_mode = 0;  // 0: ack2_ready low, 1: random, 2: high

  // Reference model state (what the outputs must be after each edge).
  logic        m_valid, m_light, m_have, m_tready, m_ack2_valid;
  logic [30:0] m_seqno;
  logic [31:0] m_rtt, m_rttvar, m_buf, m_rate, m_cap, m_ack2_ackno;
  int          m_mal, m_stale, m_drop;
  wq_t         pkt;
  bit          pkt_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_light = 0; m_have = 0; m_tready = 1; m_ack2_valid = 0;
    m_seqno = '0; m_rtt = '0; m_rttvar = '0; m_buf = '0; m_rate = '0; m_cap = '0;
    m_ack2_ackno = '0; m_mal = 0; m_stale = 0; m_drop = 0;
    pkt.delete();
  endtask

  // Judge a whole packet from its word list.
  task automatic apply_packet(input logic old2, input logic rdy);
    int          n;
    logic        ok, full;
    logic [30:0] sq, d;
    n  = pkt.size();
    ok = 1'b0;
    if (n >= 5)
      ok = pkt[0][31] && (pkt[0][30:16] == 15'd2) && !pkt[4][31] && (n == 5 || n >= 10);
    if (!ok) begin
      m_mal = sat(m_mal);
    end else begin
      full = (n >= 10);
      sq   = pkt[4][30:0];
      d    = sq - m_seqno;
      if (!m_have || (d >= 31'd1 && d < 31'h4000_0000)) begin
        m_valid = 1; m_have = 1; m_seqno = sq; m_light = !full;
        if (full) begin
          m_rtt = pkt[5]; m_rttvar = pkt[6]; m_buf = pkt[7];
`ifdef ACK_RATE_FIELDS_EN
          m_rate = pkt[8]; m_cap = pkt[9];
`endif
        end
      end else begin
        m_stale = sat(m_stale);
      end
      if (full) begin
        if (old2 && !rdy) m_drop = sat(m_drop);
        m_ack2_valid = 1; m_ack2_ackno = pkt[1];
      end
    end
  endtask

  // One clock: inputs sampled mid-cycle, model advanced just after the edge.
  task automatic tick(output logic acc);
    logic rdy, last, en, rst, old2;
    logic [31:0] w;
    case (rdy_mode)
      0:       ack2_ready = 1'b0;
      1:       ack2_ready = 1'($urandom_range(0, 1));
      default: ack2_ready = 1'b1;
    endcase
    @(negedge core_clk);
    rst = core_rst_n; rdy = ack2_ready; w = bus.in_tdata; last = bus.in_tlast; en = ack_en;
    acc = rst && bus.in_tvalid && m_tready;
    @(posedge core_clk);
    #1;
    if (!rst) begin
      model_reset();
    end else begin
      m_valid  = 0;
      m_tready = 1;
      old2     = m_ack2_valid;
      if (rdy) m_ack2_valid = 0;
      if (acc) begin
        if (pkt.size() == 0) pkt_en = en;
        pkt.push_back(w);
        if (last) begin
          if (pkt_en) begin
            apply_packet(old2, rdy);
            m_tready = 0;
          end
          pkt.delete();
        end
      end
    end
  endtask

  task automatic idle(input int n);
    logic a;
    bus.in_tvalid = 1'b0;
    bus.in_tlast  = 1'b0;
    repeat (n) tick(a);
  endtask

  task automatic send_pkt(input wq_t words, input bit en, input int max_gap, input int n_send);
    logic a;
    int   tries;
    ack_en = en;
    for (int i = 0; i < words.size() && i < n_send; i++) begin
      repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) begin
        bus.in_tvalid = 1'b0;
        bus.in_tdata  = $urandom;
        bus.in_tlast  = 1'($urandom_range(0, 1));
        tick(a);
      end
      bus.in_tvalid = 1'b1;
      bus.in_tdata  = words[i];
      bus.in_tlast  = (i == words.size() - 1);
      tries = 0;
      do begin tick(a); tries++; end while (!a && tries < 16);
      if (!a) begin
        n_cmp++; n_fail++;
        $display("FAIL beat_accept: beat %0d not accepted within 16 cycles", i);
      end
    end
    bus.in_tvalid = 1'b0;
    bus.in_tlast  = 1'b0;
  endtask

  function automatic wq_t mk_full(input logic [31:0] sub, input logic [30:0] seq,
                                  input logic [31:0] rtt, input logic [31:0] rv,
                                  input logic [31:0] bf, input logic [31:0] rate,
                                  input logic [31:0] cap);
    wq_t q;
    q.push_back({1'b1, 15'd2, 16'h0000});
    q.push_back(sub);
    q.push_back($urandom);
    q.push_back($urandom);
    q.push_back({1'b0, seq});
    q.push_back(rtt); q.push_back(rv); q.push_back(bf); q.push_back(rate); q.push_back(cap);
    return q;
  endfunction

  function automatic wq_t mk_light(input logic [30:0] seq);
    wq_t q;
    q = mk_full($urandom, seq, $urandom, $urandom, $urandom, $urandom, $urandom);
    while (q.size() > 5) q.pop_back();
    return q;
  endfunction

  // Single compare process: every cycle, DUT outputs against the model.
  always @(negedge core_clk) begin
    if (cmp_en) begin
      check("ack_valid",     32'(ack_valid),     32'(m_valid));
      check("ack_light",     32'(ack_light),     32'(m_light));
      check("ack_seqno",     32'(ack_seqno),     32'(m_seqno));
      check("ack_rtt",       ack_rtt,            m_rtt);
      check("ack_rttvar",    ack_rttvar,         m_rttvar);
      check("ack_avail_buf", ack_avail_buf,      m_buf);
      check("ack_rcv_rate",  ack_rcv_rate,       m_rate);
      check("ack_link_cap",  ack_link_cap,       m_cap);
      check("ack2_valid",    32'(ack2_valid),    32'(m_ack2_valid));
      check("ack2_ackno",    ack2_ackno,         m_ack2_ackno);
      check("malformed_cnt", 32'(malformed_cnt), 32'(m_mal));
      check("stale_cnt",     32'(stale_cnt),     32'(m_stale));
      check("ack2_drop_cnt", 32'(ack2_drop_cnt), 32'(m_drop));
      check("in_tready",     32'(bus.in_tready), 32'(m_tready));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t         q;
    logic [31:0] w, off;
    logic [30:0] seq;
    int          len;

    bus.in_tvalid = 1'b0; bus.in_tlast = 1'b0; bus.in_tdata = '0; bus.in_tkeep = 4'hF;
    model_reset();
    core_rst_n = 1'b0;
    idle(1);
    cmp_en = 1'b1;
    idle(1);
    core_rst_n = 1'b1;
    idle(2);
    check("rst_ack_seqno", 32'(ack_seqno), 32'd0);
    check("rst_ack2_valid", 32'(ack2_valid), 32'd0);

    // Full ACK, ACK2 held while ack2_ready stays low.
    rdy_mode = 0;
    send_pkt(mk_full(32'd7, 31'd100, 32'd5000, 32'd250, 32'd8192, 32'd1000, 32'd2000), 1'b1, 0, 99);
    check("t1_valid", 32'(ack_valid), 32'd1);
    check("t1_seqno", 32'(ack_seqno), 32'd100);
    check("t1_rtt", ack_rtt, 32'd5000);
    check("t1_rttvar", ack_rttvar, 32'd250);
    check("t1_buf", ack_avail_buf, 32'd8192);
`ifdef ACK_RATE_FIELDS_EN
    check("t1_rate", ack_rcv_rate, 32'd1000);
    check("t1_cap", ack_link_cap, 32'd2000);
`else
    check("t1_rate", ack_rcv_rate, 32'd0);
    check("t1_cap", ack_link_cap, 32'd0);
`endif
    check("t1_ack2_ackno", ack2_ackno, 32'd7);
    idle(1);
    check("t1_pulse_end", 32'(ack_valid), 32'd0);
    idle(4);
    check("t1_ack2_held", 32'(ack2_valid), 32'd1);
    rdy_mode = 2;
    idle(1);
    check("t1_ack2_taken", 32'(ack2_valid), 32'd0);
    rdy_mode = 0;

    // Light ACK moves only the sequence number.
    send_pkt(mk_light(31'd150), 1'b1, 0, 99);
    idle(1);
    check("t2_seqno", 32'(ack_seqno), 32'd150);
    check("t2_light", 32'(ack_light), 32'd1);
    check("t2_rtt", ack_rtt, 32'd5000);
    check("t2_no_ack2", 32'(ack2_valid), 32'd0);

    // Stale then duplicate full ACKs; second ACK2 overwrites the first.
    send_pkt(mk_full(32'd8, 31'd140, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5), 1'b1, 0, 99);
    send_pkt(mk_full(32'd9, 31'd150, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5), 1'b1, 0, 99);
    idle(1);
    check("t3_stale", 32'(stale_cnt), 32'd2);
    check("t3_drop", 32'(ack2_drop_cnt), 32'd1);
    check("t3_seqno", 32'(ack_seqno), 32'd150);
    check("t3_ackno", ack2_ackno, 32'd9);
    check("t3_rtt_kept", ack_rtt, 32'd5000);
    rdy_mode = 2;
    idle(1);
    rdy_mode = 0;

    // Wrap-aware window, including the 2^30 boundary.
    send_pkt(mk_light(31'h3FFF_FFF0), 1'b1, 1, 99);
    send_pkt(mk_light(31'h7FFF_FFE0), 1'b1, 1, 99);
    send_pkt(mk_light(31'h7FFF_FFF0), 1'b1, 1, 99);
    check("t4_pre", 32'(ack_seqno), 32'h7FFF_FFF0);
    send_pkt(mk_light(31'h0000_0005), 1'b1, 1, 99);
    check("t4_wrap", 32'(ack_seqno), 32'h0000_0005);
    send_pkt(mk_light(31'h4000_0005), 1'b1, 1, 99);
    send_pkt(mk_light(31'h4000_0004), 1'b1, 1, 99);
    idle(1);
    check("t4_edge", 32'(ack_seqno), 32'h4000_0004);
    check("t4_stale", 32'(stale_cnt), 32'd3);

    // Malformed lengths/types and a skipped packet, with random gaps.
    q = mk_full(32'd11, 31'h4000_0100, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    while (q.size() > 7) q.pop_back();
    send_pkt(q, 1'b1, 2, 99);
    q = mk_full(32'd12, 31'h4000_0100, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    q[0] = {1'b1, 15'd6, 16'h0000};
    send_pkt(q, 1'b1, 2, 99);
    send_pkt(mk_full(32'd13, 31'h4000_0100, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5), 1'b0, 2, 99);
    idle(2);
    check("t5_malformed", 32'(malformed_cnt), 32'd2);
    check("t5_stale", 32'(stale_cnt), 32'd3);
    check("t5_seqno", 32'(ack_seqno), 32'h4000_0004);
    check("t5_no_ack2", 32'(ack2_valid), 32'd0);

    // Reset in the middle of a full ACK, then a fresh start.
    send_pkt(mk_full(32'd14, 31'd1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5), 1'b1, 0, 6);
    core_rst_n = 1'b0;
    idle(1);
    core_rst_n = 1'b1;
    check("t6_rst_seqno", 32'(ack_seqno), 32'd0);
    check("t6_rst_mal", 32'(malformed_cnt), 32'd0);
    check("t6_rst_stale", 32'(stale_cnt), 32'd0);
    send_pkt(mk_full(32'd15, 31'h7000_0000, 32'd77, 32'd2, 32'd3, 32'd4, 32'd5), 1'b1, 0, 99);
    check("t6_valid", 32'(ack_valid), 32'd1);
    check("t6_seqno", 32'(ack_seqno), 32'h7000_0000);
    check("t6_rtt", ack_rtt, 32'd77);
    idle(2);

    // Random packets against the model.
    for (int k = 0; k < 200; k++) begin
      rdy_mode = $urandom_range(0, 2);
      case ($urandom_range(0, 5))
        0:       off = 32'd0;
        1:       off = 32'($urandom_range(1, 100));
        2:       off = -32'($urandom_range(1, 100));
        3:       off = 32'h4000_0000;
        4:       off = 32'h3FFF_FFFF;
        default: off = $urandom;
      endcase
      seq = m_seqno + off[30:0];
      q = mk_full($urandom, seq, $urandom, $urandom, $urandom, $urandom, $urandom);
      case ($urandom_range(0, 3))
        0: q.push_back($urandom);
        1: ;
        2: while (q.size() > 5) q.pop_back();
        default: begin
          len = $urandom_range(1, 12);
          while (q.size() > len) q.pop_back();
          while (q.size() < len) q.push_back($urandom);
        end
      endcase
      if ($urandom_range(0, 9) == 0) begin w = q[0]; w[31] = 1'b0; q[0] = w; end
      if ($urandom_range(0, 7) == 0) begin w = q[0]; w[30:16] = 15'($urandom); q[0] = w; end
      if (q.size() > 4 && $urandom_range(0, 9) == 0) begin w = q[4]; w[31] = 1'b1; q[4] = w; end
      send_pkt(q, ($urandom_range(0, 7) != 0), 2, 99);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    rdy_mode = 2;
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ack_parser.md
Name: ack_parser

Overview:
- Downstream consumer of the UDT decode stage's control-packet stream; qualified by decode's `ACK_en`.
- Parses full and light ACK control packets into registered fields for the sender's congestion and retransmit logic.
- Filters stale or duplicate ACK sequence numbers with 31-bit wrap-aware compare.
- For every full ACK, raises a held ACK2 request carrying the ACK sub-sequence number for the packet builder.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, stream width; only 32 is supported (one UDT word per beat, MSB = first byte on wire).
- CNT_W, 16, width of the saturating statistics counters.
- ACK_TYPE, 15'h0002, expected control type in word0[30:16].

Ports:
- core_clk  in  1  clock
- core_rst_n  in  1  synchronous active-low reset
- in_tdata  in  32  packet word from decode
- in_tkeep  in  4  byte enables; ignored (word-granular)
- in_tvalid  in  1  beat valid
- in_tready  out  1  beat ready
- in_tlast  in  1  last beat of packet
- ack_en  in  1  decode's ACK_en; level, stable for the whole packet
- ack_valid  out  1  one-cycle pulse: new ACK fields committed
- ack_light  out  1  committed ACK was light (only ack_seqno updated)
- ack_seqno  out  31  last accepted ACK data sequence number
- ack_rtt  out  32  RTT field (us)
- ack_rttvar  out  32  RTT variance field
- ack_avail_buf  out  32  peer available buffer (packets)
- ack_rcv_rate  out  32  packets/s (optional feature)
- ack_link_cap  out  32  packets/s (optional feature)
- ack2_valid  out  1  ACK2 request pending
- ack2_ackno  out  32  ACK sub-sequence number to echo
- ack2_ready  in  1  ACK2 request taken
- malformed_cnt  out  CNT_W  malformed packets dropped
- stale_cnt  out  CNT_W  stale/duplicate ACKs not applied
- ack2_drop_cnt  out  CNT_W  ACK2 requests overwritten before taken

Behaviour:
- Reset (core_rst_n low at a core_clk edge) sets all outputs to 0, have_seq=0, state=IDLE; a packet in flight is discarded and is not counted.
- Beat index b counts accepted beats (in_tvalid & in_tready) from 0.
- States and transitions:
  - IDLE: in_tready=1. On beat 0: if ack_en=0 → SKIP; else latch type check, → HDR.
  - SKIP: in_tready=1; consume until in_tlast, → IDLE. No counters change.
  - HDR: b1 latches sub-seq, b2 timestamp (discarded), b3 dest socket (discarded); → BODY after b3.
  - BODY: b4 seqno (bit31 must be 0), b5 rtt, b6 rttvar, b7 avail_buf, b8 rcv_rate, b9 link_cap; beats after b9 discarded.
  - COMMIT: entered on the in_tlast beat; lasts 1 cycle with in_tready=0; → IDLE.
- Classification at in_tlast:
  - Last beat b4 → light.
  - Last beat b≥9 → full.
  - Last beat b≤3 or 5..8, type≠ACK_TYPE, word0 bit31=0, or seqno bit31=1 → malformed; malformed_cnt++ and nothing else changes.
  - in_tlast in SKIP or HDR still goes through COMMIT only if in HDR (malformed).
- Sequence filter, with d=(new−ack_seqno) mod 2^31:
  - Accept if have_seq=0, or 1≤d<2^30.
  - Otherwise stale: stale_cnt++, fields unchanged, ack_valid not pulsed.
- Accepted light ACK: ack_seqno updated, ack_light=1, ack_valid pulse in COMMIT cycle; other fields hold.
- Accepted full ACK: all fields updated, ack_light=0, ack_valid pulse.
- Every well-formed full ACK raises ack2_valid with ack2_ackno=sub-seq, stale or not; light ACKs never do.
  - ack2_valid holds until a cycle with ack2_ready=1, then clears next cycle.
  - If COMMIT raises a new request while one is pending and ack2_ready=0: overwrite ack2_ackno, ack2_drop_cnt++.
  - If ack2_ready=1 in that same cycle: old request is taken, new one loads, no drop.
- Field outputs change only in the COMMIT cycle; latency is 1 cycle from the tlast beat to ack_valid.
- Counters saturate at all-ones.

Optional Feature:
- Macro: ACK_RATE_FIELDS_EN.
- Defined: b8/b9 captured into ack_rcv_rate/ack_link_cap on accepted full ACK.
- Undefined: those registers are not built, outputs are tied to 0, and b8/b9 are still consumed and still required for a full ACK.

Test Plan:
- Reset, then full ACK (type 2, sub-seq 7, seqno 100, rtt 5000, rttvar 250, buf 8192, rate 1000, cap 2000), ack2_ready=0 → ack_valid pulse 1 cycle after tlast; fields equal values; ack2_valid=1, ack2_ackno=7; held until ack2_ready.
- Light ACK seqno 150 after above → ack_seqno=150, ack_light=1, rtt still 5000, no ACK2.
- Full ACK seqno 140 (stale) then seqno 150 (duplicate) → stale_cnt=2, ack_seqno=150, ACK2 raised for each; second ACK2 with ack2_ready=0 → ack2_drop_cnt=1.
- Wrap: ack_seqno=0x7FFFFFF0, then ACK seqno 0x00000005 → accepted (d=0x15).
- 7-beat ACK; type-6 packet with ack_en=1; packet with ack_en=0 → malformed_cnt=2, third ignored with no counters changed; in_tvalid with random gaps does not alter results.
- core_rst_n low at b5 of a full ACK → outputs 0, state IDLE; next complete ACK is accepted with have_seq=0 behaviour.
